spi_slave_core: RTL and testbench

//  Synthesizable SPI target (slave) front end for the crypto accelerator. It deserializes

---
 rtl/spi_slave_core.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_slave_core.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI target front end: oversampled 1/2/4-lane MOSI deserializer feeding a FWFT byte FIFO.
// Optional MISO transmit path is built when SPI_SLAVE_TX_EN is defined.
module spi_slave_core #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic [3:0] mosi,
  input  logic [1:0] lane_mode,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overflow,
  input  logic       ovf_clr,
  output logic       rx_frame_end,
  output logic       rx_partial,
  output logic [3:0] miso,
  output logic [3:0] miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_END    = 2'd2;

  function automatic logic [2:0] lanes_of(input logic [1:0] m);
    case (m)
      2'd1:    return 3'd2;
      2'd2:    return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sh;
  logic [SYNC_STAGES-1:0] cs_sh;
  logic [3:0]             mosi_sh [SYNC_STAGES];
  logic                   sclk_d;
  logic                   cs_d;

  // cs_n chain resets high so reset release never looks like a select edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sh <= '0;
      cs_sh   <= '1;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) mosi_sh[i] <= '0;
      sclk_d  <= 1'b0;
      cs_d    <= 1'b1;
    end else begin
      sclk_sh    <= {sclk_sh[SYNC_STAGES-2:0], sclk};
      cs_sh      <= {cs_sh[SYNC_STAGES-2:0], cs_n};
      mosi_sh[0] <= mosi;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) mosi_sh[i] <= mosi_sh[i-1];
      sclk_d     <= sclk_sh[SYNC_STAGES-1];
      cs_d       <= cs_sh[SYNC_STAGES-1];
    end
  end

  logic       sclk_s, cs_s;
  logic [3:0] mosi_s;
  logic       sclk_rise, cs_fall, cs_rise;

  assign sclk_s    = sclk_sh[SYNC_STAGES-1];
  assign cs_s      = cs_sh[SYNC_STAGES-1];
  assign mosi_s    = mosi_sh[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  logic [1:0] state;
  logic [2:0] lanes;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       push_pend;
  logic [7:0] shreg_nxt;
  logic [2:0] bit_cnt_nxt;

  always_comb begin
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt + lanes;
    for (int unsigned k = 0; k < 4; k++) begin
      if (k < 32'(lanes)) shreg_nxt[bit_cnt + 3'(k)] = mosi_s[k];
    end
  end

  // A sample on the same cycle as cs_n rise is taken before entering END
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lanes     <= 3'd1;
      bit_cnt   <= '0;
      shreg     <= '0;
      push_pend <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state   <= ST_ACTIVE;
            lanes   <= lanes_of(lane_mode);
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        ST_ACTIVE: begin
          if (sclk_rise) begin
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            push_pend <= (bit_cnt_nxt == 3'd0);
          end
          if (cs_rise) state <= ST_END;
        end
        ST_END:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rx_frame_end = (state == ST_END);
  assign rx_partial   = (state == ST_END) && (bit_cnt != 3'd0);

  // Storage is the memory plus the rx_data output register; together they hold FIFO_DEPTH bytes
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   mem_cnt;
  logic [AW:0]   total;
  logic          full, pop, push_ok, load_out;

  assign total    = mem_cnt + (AW+1)'(rx_valid);
  assign full     = (total >= DEPTH_C);
  assign pop      = rx_valid & rx_ready;
  assign push_ok  = push_pend & (~full | pop);
  assign load_out = (mem_cnt != '0) & (~rx_valid | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      mem_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (load_out) begin
        rx_data  <= mem[rptr];
        rptr     <= rptr + AW'(1);
        rx_valid <= 1'b1;
      end else if (pop) begin
        rx_valid <= 1'b0;
      end
      case ({push_ok, load_out})
        2'b10:   mem_cnt <= mem_cnt + (AW+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (AW+1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      if (ovf_clr)
        rx_overflow <= 1'b0;
      else if (push_pend && !push_ok)
        rx_overflow <= 1'b1;
    end
  end

`ifdef SPI_SLAVE_TX_EN
  logic       sclk_fall;
  logic [7:0] txsh;
  logic [2:0] tx_cnt;
  logic       tx_load_start, tx_wrap;

  assign sclk_fall     = ~sclk_s & sclk_d;
  assign tx_load_start = (state == ST_IDLE) & cs_fall;
  assign tx_wrap       = (state == ST_ACTIVE) & sclk_fall & ((tx_cnt + lanes) == 3'd0);
  assign tx_ready      = (tx_load_start | tx_wrap) & tx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txsh   <= '0;
      tx_cnt <= '0;
    end else if (tx_load_start) begin
      txsh   <= tx_valid ? tx_data : 8'h00;
      tx_cnt <= '0;
    end else if ((state == ST_ACTIVE) && sclk_fall) begin
      tx_cnt <= tx_cnt + lanes;
      if (tx_wrap)
        txsh <= tx_valid ? tx_data : 8'h00;
      else
        txsh <= txsh >> lanes;
    end
  end

  always_comb begin
    miso    = '0;
    miso_oe = '0;
    if (state == ST_ACTIVE) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (k < 32'(lanes)) begin
          miso[k]    = txsh[k];
          miso_oe[k] = 1'b1;
        end
      end
    end
  end
`else
  logic unused_tx;
  assign unused_tx = ^{tx_data, tx_valid};
  assign miso      = '0;
  assign miso_oe   = '0;
  assign tx_ready  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed and randomized bench for spi_slave_core against a byte-queue reference model.
module tb_spi_slave_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic [3:0] mosi = '0;
  logic [1:0] lane_mode = '0;
  logic       rx_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_overflow, rx_frame_end, rx_partial, tx_ready;
  logic [3:0] miso, miso_oe;

  spi_slave_core #(.FIFO_DEPTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .lane_mode(lane_mode), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_overflow(rx_overflow), .ovf_clr(ovf_clr),
    .rx_frame_end(rx_frame_end), .rx_partial(rx_partial), .miso(miso),
    .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0, pt_cnt = 0, txacc = 0;

  always @(posedge clk) begin
    if (rx_frame_end === 1'b1) fe_cnt <= fe_cnt + 1;
    if (rx_partial === 1'b1) pt_cnt <= pt_cnt + 1;
    if (tx_ready === 1'b1 && tx_valid) txacc <= txacc + 1;
  end

  logic [7:0] expq[$];
  bit         model_ovf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One sclk period; with lat set, checks rx_valid rises exactly 5 clk after the raw edge
  task automatic pulse(input bit lat);
    @(posedge clk);
    #1 sclk = 1'b1;
    if (lat) begin
      repeat (4) @(posedge clk);
      @(negedge clk) chk("latency_4clk", rx_valid, 1'b0);
      @(posedge clk);
      @(negedge clk) chk("latency_5clk", rx_valid, 1'b1);
      clks(1);
    end else begin
      clks(6);
    end
    sclk = 1'b0;
    clks(6);
  endtask

  function automatic int lanes_for(input logic [1:0] lm);
    return (lm == 2'd1) ? 2 : (lm == 2'd2) ? 4 : 1;
  endfunction

  task automatic send_frame(input string tag, input logic [1:0] lm, input bit stream[$],
                            input bit lat, input bit scramble);
    int L, steps, fe0, pt0, nbytes;
    logic [7:0] b;
    L = lanes_for(lm);
    steps = stream.size() / L;
    lane_mode = lm;
    clks(2);
    cs_n = 1'b0;
    clks(6);
    if (scramble) lane_mode = 2'($urandom);
    for (int s = 0; s < steps; s++) begin
      mosi = 4'($urandom);
      for (int k = 0; k < L; k++) mosi[k] = stream[s*L+k];
      pulse(lat && (s == steps - 1));
    end
    clks(4);
    fe0 = fe_cnt;
    pt0 = pt_cnt;
    cs_n = 1'b1;
    clks(8);
    chk({tag, "_frame_end"}, fe_cnt - fe0, 1);
    chk({tag, "_partial"}, pt_cnt - pt0, ((stream.size() % 8) != 0) ? 1 : 0);
    nbytes = stream.size() / 8;
    for (int j = 0; j < nbytes; j++) begin
      for (int i = 0; i < 8; i++) b[i] = stream[8*j+i];
      if (expq.size() < 8) expq.push_back(b);
      else model_ovf = 1'b1;
    end
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    for (int i = 0; i < 40 && rx_valid !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, rx_valid, 1'b1);
    e = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
    chk({tag, "_data"}, rx_data, e);
    rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (expq.size() > 0) begin
      pop_check($sformatf("%s_pop%0d", tag, n));
      n++;
    end
    clks(3);
    chk({tag, "_empty"}, rx_valid, 1'b0);
  endtask

  function automatic void add_byte(inout bit q[$], input logic [7:0] v);
    for (int i = 0; i < 8; i++) q.push_back(v[i]);
  endfunction

  initial begin
    bit st[$];
    int lm, L, nb, extra, fe0;
    logic [7:0] c3;

    // reset state
    clks(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ovf", rx_overflow, 0);
    chk("rst_fe", rx_frame_end, 0);
    chk("rst_partial", rx_partial, 0);
    chk("rst_miso", {miso_oe, miso}, 0);
    chk("rst_txready", tx_ready, 0);
    rst_n = 1'b1;
    clks(4);

    // 1 lane 0xA5 with latency check
    st = {};
    add_byte(st, 8'hA5);
    send_frame("a5", 2'd0, st, 1'b1, 1'b0);
    drain("a5");

    // 4 lanes, three bytes in six sclk
    st = {};
    add_byte(st, 8'h12); add_byte(st, 8'h34); add_byte(st, 8'h56);
    send_frame("q4", 2'd2, st, 1'b0, 1'b0);
    chk("q4_ovf", rx_overflow, 0);
    drain("q4");

    // 2 lanes, ten bytes with no consumer: last two dropped
    st = {};
    for (int i = 0; i < 10; i++) add_byte(st, 8'(i));
    send_frame("ovf", 2'd1, st, 1'b0, 1'b0);
    chk("ovf_set", rx_overflow, model_ovf);
    @(posedge clk);
    #1 ovf_clr = 1'b1;
    clks(1);
    ovf_clr = 1'b0;
    model_ovf = 1'b0;
    clks(1);
    chk("ovf_clr", rx_overflow, model_ovf);
    drain("ovf");

    // partial frame of 5 bits
    st = {};
    for (int i = 0; i < 5; i++) st.push_back(1'($urandom));
    send_frame("part", 2'd0, st, 1'b0, 1'b0);
    chk("part_novalid", rx_valid, 0);

    // reset mid-frame, then a clean 0x3C
    lane_mode = 2'd0;
    cs_n = 1'b0;
    clks(6);
    for (int i = 0; i < 4; i++) begin
      mosi = 4'($urandom);
      pulse(1'b0);
    end
    fe0 = fe_cnt;
    rst_n = 1'b0;
    clks(2);
    cs_n = 1'b1;
    clks(3);
    rst_n = 1'b1;
    clks(6);
    chk("rstmid_nofe", fe_cnt - fe0, 0);
    chk("rstmid_novalid", rx_valid, 0);
    st = {};
    add_byte(st, 8'h3C);
    send_frame("r3c", 2'd0, st, 1'b0, 1'b0);
    drain("r3c");

    // random frames, lane_mode scrambled mid-frame
    for (int f = 0; f < 12; f++) begin
      lm = $urandom_range(0, 3);
      L = lanes_for(2'(lm));
      nb = $urandom_range(1, 3);
      extra = $urandom_range(0, 8 / L - 1);
      st = {};
      for (int j = 0; j < nb; j++) add_byte(st, 8'($urandom));
      for (int j = 0; j < extra * L; j++) st.push_back(1'($urandom));
      send_frame($sformatf("rnd%0d", f), 2'(lm), st, 1'b0, 1'b1);
      drain($sformatf("rnd%0d", f));
    end

`ifdef SPI_SLAVE_TX_EN
    c3 = 8'hC3;
    tx_data = c3;
    tx_valid = 1'b1;
    lane_mode = 2'd0;
    mosi = '0;
    clks(2);
    fe0 = txacc;
    cs_n = 1'b0;
    clks(6);
    tx_valid = 1'b0;
    chk("tx_accept", txacc - fe0, 1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tx_bit%0d", i), miso[0], c3[i]);
      chk($sformatf("tx_oe%0d", i), miso_oe, 4'b0001);
      pulse(1'b0);
    end
    clks(4);
    cs_n = 1'b1;
    clks(8);
    chk("tx_once", txacc - fe0, 1);
    chk("tx_idle_miso", {miso_oe, miso}, 0);
    expq.push_back(8'h00);
    drain("tx");
`else
    c3 = 8'hFF;
    tx_data = c3;
    tx_valid = 1'b1;
    lane_mode = 2'd2;
    clks(2);
    cs_n = 1'b0;
    clks(6);
    chk("notx_miso", {miso_oe, miso}, 0);
    chk("notx_ready", tx_ready, 0);
    cs_n = 1'b1;
    tx_valid = 1'b0;
    clks(8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
